risc_v: RTL and testbench

Multicycle RV32I-subset processor core with a unified internal instruction/data memory. It is the top of the CPU design and has no ports other than clock and reset. All architectural state (PC, register file, memory) is internal and is checked hierarchically by the bench. Each instruction passes through a shared-datapath FSM over 3–5 clock cycles.

---
 rtl/risc_v.sv | 179 +++++++++++++++++
 tb/tb_risc_v.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v.sv
`default_nettype none
// ============================================================================
//  Module      : risc_v
//  Description : Multicycle RV32I-subset core with a unified word-addressed
//                instruction/data memory. Shared datapath driven by a five
//                state FSM (FETCH, DECODE, EXECUTE, MEM, WRITEBACK).
//                Memory has no reset; its image is placed by the environment.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_v #(
    parameter int MEM_WORDS = 1024
) (
    input logic clk,
    input logic rst
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    // Architectural state (probe names are fixed for hierarchical access)
    logic [31:0] mem  [0:MEM_WORDS-1];
    logic [31:0] regs [0:31];
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] ir;
    state_t      state;

    // Datapath holding registers
    logic [31:0] a_q, b_q, target_q, alu_out_q, mdr_q;

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // Immediates
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};

    // Memory read ports: one for fetch, one for data
    logic [31:0] fetch_word, data_word;
    assign fetch_word = mem[pc[AW+1:2]];
    assign data_word  = mem[alu_out_q[AW+1:2]];

    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_lui, supported, taken;
    logic [31:0] op_b, alu_res;

    // Decode class of instruction and compute the ALU result
    always_comb begin
        is_r   = (opcode == OP_R) &&
                 ((funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        is_i   = (opcode == OP_I) && (funct3 != 3'b011) &&
                 ((funct3 != 3'b001) || (funct7 == 7'h00)) &&
                 ((funct3 != 3'b101) || (funct7 == 7'h00) || (funct7 == 7'h20));
        is_lw  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
        is_sw  = (opcode == OP_STORE) && (funct3 == 3'b010);
        is_br  = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
        is_jal = (opcode == OP_JAL);
        is_lui = (opcode == OP_LUI);
        supported = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_lui;
        // BEQ when funct3[0]=0, BNE when funct3[0]=1
        taken  = (a_q == b_q) ^ funct3[0];

        op_b    = is_r ? b_q : imm_i;
        alu_res = '0;
        case (funct3)
            3'b000: begin
                // ir[30] is an immediate bit for ADDI, so only R-type subtracts
                if (is_r && ir[30]) alu_res = a_q - op_b;
                else                alu_res = a_q + op_b;
            end
            3'b001: alu_res = a_q << op_b[4:0];
            3'b010: alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
            3'b011: alu_res = {31'b0, a_q < op_b};
            3'b100: alu_res = a_q ^ op_b;
            3'b101: begin
                if (ir[30]) alu_res = $signed(a_q) >>> op_b[4:0];
                else        alu_res = a_q >> op_b[4:0];
            end
            3'b110: alu_res = a_q | op_b;
            default: alu_res = a_q & op_b;
        endcase
    end

    // Control FSM together with PC, IR, datapath registers and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            old_pc    <= '0;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            target_q  <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir     <= fetch_word;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                    state  <= S_DECODE;
                end
                S_DECODE: begin
                    a_q      <= regs[rs1];
                    b_q      <= regs[rs2];
                    target_q <= old_pc + (is_jal ? imm_j : imm_b);
                    state    <= supported ? S_EXECUTE : S_FETCH;
                end
                S_EXECUTE: begin
                    if (is_lw || is_sw) begin
                        alu_out_q <= a_q + (is_sw ? imm_s : imm_i);
                        state     <= S_MEM;
                    end else if (is_br) begin
                        if (taken) pc <= target_q;
                        state <= S_FETCH;
                    end else if (is_jal) begin
                        if (rd != 5'd0) regs[rd] <= old_pc + 32'd4;
                        pc    <= target_q;
                        state <= S_FETCH;
                    end else begin
                        alu_out_q <= is_lui ? imm_u : alu_res;
                        state     <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (is_lw) begin
                        mdr_q <= data_word;
                        state <= S_WRITEBACK;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    if (rd != 5'd0) regs[rd] <= is_lw ? mdr_q : alu_out_q;
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Store port; reset suppresses a store that is in flight
    always_ff @(posedge clk) begin
        if (!rst && (state == S_MEM) && is_sw) begin
            mem[alu_out_q[AW+1:2]] <= b_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_risc_v.sv
`default_nettype none
// Bench for risc_v: directed programs from the test plan plus random programs,
// each compared against an instruction-level interpreter of the ISA.
module tb_risc_v;

    logic clk = 1'b0;
    logic rst = 1'b1;

    risc_v #(.MEM_WORDS(1024)) dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    logic [31:0] mmem  [1024];
    logic [31:0] mpc;
    logic [31:0] prog  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] enc_u(int imm, int rd);
        return {imm[19:0], rd[4:0], 7'h37};
    endfunction

    // RV32I arithmetic semantics
    function automatic logic [31:0] alu_ref(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Execute one instruction in the model; report its cycle count and effects
    task automatic step(output int cyc, output logic [4:0] rd_o, output logic st, output logic [9:0] widx);
        logic [31:0] ins, a, b, ii, is_, ib, ij, res, nxt, addr;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic wr;
        ins = mmem[mpc[11:2]];
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
        rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
        a = mregs[rs1]; b = mregs[rs2];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        cyc = 2; wr = 1'b0; res = '0; nxt = mpc + 32'd4; st = 1'b0; widx = '0;
        case (op)
            7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                res = alu_ref(f3, f7[5], a, b); wr = 1'b1; cyc = 4;
            end
            7'h13: if (f3 != 3'd3 && (f3 != 3'd1 || f7 == 7'h00) &&
                       (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20)) begin
                res = alu_ref(f3, (f3 == 3'd5) && f7[5], a, ii); wr = 1'b1; cyc = 4;
            end
            7'h37: begin res = {ins[31:12], 12'b0}; wr = 1'b1; cyc = 4; end
            7'h03: if (f3 == 3'd2) begin
                addr = a + ii; res = mmem[addr[11:2]]; wr = 1'b1; cyc = 5;
            end
            7'h23: if (f3 == 3'd2) begin
                addr = a + is_; mmem[addr[11:2]] = b; st = 1'b1; widx = addr[11:2]; cyc = 4;
            end
            7'h63: if (f3 == 3'd0 || f3 == 3'd1) begin
                cyc = 3;
                if ((a == b) != f3[0]) nxt = mpc + ib;
            end
            7'h6f: begin res = mpc + 32'd4; wr = 1'b1; nxt = mpc + ij; cyc = 3; end
            default: ;
        endcase
        if (wr && rd != 5'd0) mregs[rd] = res;
        rd_o = rd;
        mpc = nxt;
    endtask

    // Load prog into DUT and model, apply a 3-edge reset, release
    task automatic start();
        logic [31:0] w;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            w = (i < prog.size()) ? prog[i] : 32'h0;
            dut.mem[i] = w;
            mmem[i] = w;
        end
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mpc = '0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); @(negedge clk);
            check("rst_pc", dut.pc, 32'h0);
            check("rst_state", 32'(dut.state), 32'h0);
        end
        check("rst_ir", dut.ir, 32'h0);
        check("rst_old_pc", dut.old_pc, 32'h0);
        for (int i = 0; i < 32; i++) check("rst_reg", dut.regs[i], 32'h0);
        rst = 1'b0;
    endtask

    // Run n instructions, checking state after each one completes
    task automatic run(input string name, input int n);
        int cyc;
        logic [4:0] rd;
        logic st;
        logic [9:0] widx;
        for (int s = 0; s < n; s++) begin
            step(cyc, rd, st, widx);
            repeat (cyc) @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_pc%0d", name, s), dut.pc, mpc);
            check($sformatf("%s_state%0d", name, s), 32'(dut.state), 32'h0);
            check($sformatf("%s_rd%0d", name, s), dut.regs[rd], mregs[rd]);
            if (st) check($sformatf("%s_mem%0d", name, s), dut.mem[widx], mmem[widx]);
        end
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", name, i), dut.regs[i], mregs[i]);
    endtask

    task automatic gen_random();
        int kind, rd, rs1, rs2, f3, f7, imm;
        prog.delete();
        for (int k = 0; k < 24; k++) begin
            kind = $urandom_range(0, 9);
            rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
            f3 = $urandom_range(0, 7);
            case (kind)
                0, 1, 2, 3: begin
                    f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0;
                    prog.push_back(enc_r(f7, rs2, rs1, f3, rd));
                end
                4, 5: begin
                    if (f3 == 3) f3 = 2;
                    if (f3 == 1)      imm = $urandom_range(0, 31);
                    else if (f3 == 5) imm = $urandom_range(0, 31) + (($urandom_range(0, 1) == 1) ? 1024 : 0);
                    else              imm = $urandom_range(0, 4095);
                    prog.push_back(enc_i(imm, rs1, f3, rd, 7'h13));
                end
                6: prog.push_back(enc_u($urandom, rd));
                7: prog.push_back(enc_s(1024 + 4 * $urandom_range(0, 255), rs2, 0));
                8: prog.push_back(enc_i(1024 + 4 * $urandom_range(0, 255), 0, 2, rd, 7'h03));
                default: begin
                    if ($urandom_range(0, 1) == 1) prog.push_back(enc_b(8, rs2, rs1, $urandom_range(0, 1)));
                    else                           prog.push_back(enc_j(8, rd));
                end
            endcase
        end
    endtask

    initial begin
        // Arithmetic program
        prog = '{enc_i(5, 0, 0, 1, 7'h13), enc_i(-3, 0, 0, 2, 7'h13),
                 enc_r(0, 2, 1, 0, 3), enc_r(32, 2, 1, 0, 4), enc_r(0, 1, 2, 2, 5)};
        start();
        run("arith", 5);
        check("arith_x1", dut.regs[1], 32'd5);
        check("arith_x2", dut.regs[2], 32'hFFFFFFFD);
        check("arith_x3", dut.regs[3], 32'd2);
        check("arith_x4", dut.regs[4], 32'd8);
        check("arith_x5", dut.regs[5], 32'd1);
        check("arith_pc", dut.pc, 32'd20);

        // Store then load
        prog = '{enc_i(127, 0, 0, 1, 7'h13), enc_s(256, 1, 0), enc_i(256, 0, 2, 6, 7'h03)};
        start();
        run("ldst", 3);
        check("ldst_mem64", dut.mem[64], 32'h7F);
        check("ldst_x6", dut.regs[6], 32'h7F);

        // Branches
        prog = '{enc_b(8, 0, 0, 0)};
        start();
        run("beq", 1);
        check("beq_pc", dut.pc, 32'd8);
        prog = '{enc_b(8, 0, 0, 1)};
        start();
        run("bne", 1);
        check("bne_pc", dut.pc, 32'd4);

        // JAL then LUI at target
        prog = '{enc_j(12, 1), 32'h0, 32'h0, enc_u(32'h12345, 2)};
        start();
        run("jal", 2);
        check("jal_x1", dut.regs[1], 32'd4);
        check("lui_x2", dut.regs[2], 32'h12345000);

        // x0 is hardwired, shifts of a negative value
        prog = '{enc_i(9, 0, 0, 0, 7'h13), enc_u(32'h80000, 1),
                 enc_i(1024 + 4, 1, 5, 2, 7'h13), enc_i(4, 1, 5, 3, 7'h13)};
        start();
        run("shift", 4);
        check("x0_zero", dut.regs[0], 32'h0);
        check("srai", dut.regs[2], 32'hF8000000);
        check("srli", dut.regs[3], 32'h08000000);

        // Random programs; tail of zero words exercises the NOP path
        for (int t = 0; t < 4; t++) begin
            gen_random();
            start();
            run($sformatf("rnd%0d", t), 30);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
